// File: rtl/noc_inject_pkg.sv
// Shared types and sizing helpers for the multi-channel NoC injection arbiter.
package noc_inject_pkg;

  localparam int STAT_WIDTH = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic int credit_w(input int credits);
    return $clog2(credits + 1);
  endfunction

  // Channel index width; a single channel still needs one bit to index with.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/noc_inject_arbiter_if.sv
// Channel-side flit streams and router-side credit link of the injection arbiter.
interface noc_inject_arbiter_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int FLIT_WIDTH   = 32,
  parameter int DEST_WIDTH   = 6
);
  // Channel c transfers a flit on any rising edge where ch_valid[c] & ch_ready[c];
  // the router takes one flit per cycle that send_out is high and returns one
  // credit_in pulse per freed buffer slot.
  logic [NUM_CHANNELS-1:0]                 ch_valid;
  logic [NUM_CHANNELS-1:0]                 ch_ready;
  logic [NUM_CHANNELS-1:0][FLIT_WIDTH-1:0] ch_data;
  logic [NUM_CHANNELS-1:0][DEST_WIDTH-1:0] ch_dest;
  logic [NUM_CHANNELS-1:0]                 ch_is_tail;
  logic [FLIT_WIDTH-1:0]                   data_out;
  logic [DEST_WIDTH-1:0]                   dest_out;
  logic                                    is_tail_out;
  logic                                    send_out;
  logic                                    credit_in;

  modport slave (
    input  ch_valid, ch_data, ch_dest, ch_is_tail, credit_in,
    output ch_ready, data_out, dest_out, is_tail_out, send_out
  );

  modport master (
    output ch_valid, ch_data, ch_dest, ch_is_tail, credit_in,
    input  ch_ready, data_out, dest_out, is_tail_out, send_out
  );
endinterface

// File: rtl/noc_flit_fifo.sv
// Single-clock flit FIFO with combinational head read and synchronous active-high reset.
module noc_flit_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             wr_ok, rd_ok;

  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-atomic round-robin merge of NUM_CHANNELS flit streams onto one credit-based port.
// Optional NOC_INJECT_STATS_EN adds per-channel flit counters and a credit-stall counter.
module noc_inject_arbiter
  import noc_inject_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int FLIT_WIDTH   = 32,
  parameter int DEST_WIDTH   = 6,
  parameter int FIFO_DEPTH   = 4,
  parameter int CREDITS      = 2
) (
  input  logic                                  clk_noc,
  input  logic                                  rst_noc_sync,
  noc_inject_arbiter_if.slave                   bus,
  output logic                                  credit_err,
  output arb_state_e                            dbg_state,
  output logic [ptr_w(NUM_CHANNELS)-1:0]        dbg_lock_ch,
  output logic [ptr_w(NUM_CHANNELS)-1:0]        dbg_rr_ptr,
  output logic [credit_w(CREDITS)-1:0]          dbg_credit_cnt
`ifdef NOC_INJECT_STATS_EN
  ,
  output logic [NUM_CHANNELS-1:0][STAT_WIDTH-1:0] stat_flits,
  output logic [STAT_WIDTH-1:0]                 stat_stall
`endif
);
  localparam int PW = ptr_w(NUM_CHANNELS);
  localparam int CW = credit_w(CREDITS);
  localparam int EW = DEST_WIDTH + 1 + FLIT_WIDTH;
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  logic [NUM_CHANNELS-1:0] fifo_full, fifo_empty, fifo_pop, ready_vec;
  logic [EW-1:0]           fifo_head [NUM_CHANNELS];

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    assign ready_vec[g] = ~fifo_full[g] & ~rst_noc_sync;
    noc_flit_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk_noc),
      .rst     (rst_noc_sync),
      .wr_en   (bus.ch_valid[g] & ready_vec[g]),
      .wr_data ({bus.ch_dest[g], bus.ch_is_tail[g], bus.ch_data[g]}),
      .rd_en   (fifo_pop[g]),
      .rd_data (fifo_head[g]),
      .full    (fifo_full[g]),
      .empty   (fifo_empty[g])
    );
  end
  assign bus.ch_ready = ready_vec;

  function automatic logic [PW-1:0] next_ch(input logic [PW-1:0] c);
    return (c == PW'(NUM_CHANNELS - 1)) ? '0 : c + 1'b1;
  endfunction

  arb_state_e     state_q, state_d;
  logic [PW-1:0]  lock_q, lock_d, rr_q, rr_d, gnt_ch;
  logic [CW-1:0]  cnt_q;
  logic           grant, gnt_tail, credit_ok;
  int             scan_idx;
  logic [EW-1:0]  head_sel;

  assign credit_ok = (cnt_q != '0);
  assign head_sel  = fifo_head[gnt_ch];

  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    rr_d     = rr_q;
    grant    = 1'b0;
    gnt_tail = 1'b0;
    gnt_ch   = lock_q;
    fifo_pop = '0;
    scan_idx = 0;
    if (state_q == IDLE) begin
      // First non-empty channel at or after rr_q, wrapping around.
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        scan_idx = int'(rr_q) + i;
        if (scan_idx >= NUM_CHANNELS) scan_idx = scan_idx - NUM_CHANNELS;
        if (!grant && !fifo_empty[scan_idx] && credit_ok) begin
          grant    = 1'b1;
          gnt_ch   = PW'(scan_idx);
          gnt_tail = fifo_head[scan_idx][FLIT_WIDTH];
        end
      end
      if (grant) begin
        if (gnt_tail) begin
          rr_d = next_ch(gnt_ch);
        end else begin
          state_d = LOCKED;
          lock_d  = gnt_ch;
        end
      end
    end else begin
      if (!fifo_empty[lock_q] && credit_ok) begin
        grant    = 1'b1;
        gnt_tail = fifo_head[lock_q][FLIT_WIDTH];
        if (gnt_tail) begin
          state_d = IDLE;
          rr_d    = next_ch(lock_q);
        end
      end
    end
    if (grant) fifo_pop[gnt_ch] = 1'b1;
  end

  logic [FLIT_WIDTH-1:0] data_q;
  logic [DEST_WIDTH-1:0] dest_q;
  logic                  tail_q, send_q;

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      state_q    <= IDLE;
      lock_q     <= '0;
      rr_q       <= '0;
      send_q     <= 1'b0;
      data_q     <= '0;
      dest_q     <= '0;
      tail_q     <= 1'b0;
      cnt_q      <= CRED_MAX;
      credit_err <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      rr_q    <= rr_d;
      send_q  <= grant;
      if (grant) begin
        data_q <= head_sel[FLIT_WIDTH-1:0];
        tail_q <= head_sel[FLIT_WIDTH];
        dest_q <= head_sel[EW-1 -: DEST_WIDTH];
      end
      // The credit is consumed at the grant edge, i.e. as send_out rises.
      case ({grant, bus.credit_in})
        2'b10: cnt_q <= cnt_q - 1'b1;
        2'b01: begin
          if (cnt_q == CRED_MAX) credit_err <= 1'b1;
          else                   cnt_q <= cnt_q + 1'b1;
        end
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign bus.send_out    = send_q;
  assign bus.data_out    = data_q;
  assign bus.dest_out    = dest_q;
  assign bus.is_tail_out = tail_q;
  assign dbg_state       = state_q;
  assign dbg_lock_ch     = lock_q;
  assign dbg_rr_ptr      = rr_q;
  assign dbg_credit_cnt  = cnt_q;

`ifdef NOC_INJECT_STATS_EN
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      stat_flits <= '0;
      stat_stall <= '0;
    end else begin
      if (grant) stat_flits[gnt_ch] <= stat_flits[gnt_ch] + 1'b1;
      if ((~fifo_empty != '0) && !credit_ok) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed bench for noc_inject_arbiter: reset, latency, credit stall, round-robin order,
// packet locking with bubbles, and sticky credit error.
module tb_noc_inject_arbiter;
  import noc_inject_pkg::*;

  localparam int N    = 4;
  localparam int FW   = 32;
  localparam int DW   = 6;
  localparam int DEP  = 4;
  localparam int CRED = 2;
  localparam int EW   = DW + 1 + FW;

  logic       clk_noc = 1'b0;
  logic       rst_noc_sync;
  logic       credit_err;
  arb_state_e dbg_state;
  logic [1:0] dbg_lock_ch, dbg_rr_ptr, dbg_credit_cnt;
`ifdef NOC_INJECT_STATS_EN
  logic [N-1:0][STAT_WIDTH-1:0] stat_flits;
  logic [STAT_WIDTH-1:0]        stat_stall;
`endif

  noc_inject_arbiter_if #(.NUM_CHANNELS(N), .FLIT_WIDTH(FW), .DEST_WIDTH(DW)) bus ();

  noc_inject_arbiter #(
    .NUM_CHANNELS(N), .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FIFO_DEPTH(DEP), .CREDITS(CRED)
  ) dut (
    .clk_noc        (clk_noc),
    .rst_noc_sync   (rst_noc_sync),
    .bus            (bus),
    .credit_err     (credit_err),
    .dbg_state      (dbg_state),
    .dbg_lock_ch    (dbg_lock_ch),
    .dbg_rr_ptr     (dbg_rr_ptr),
    .dbg_credit_cnt (dbg_credit_cnt)
`ifdef NOC_INJECT_STATS_EN
    ,
    .stat_flits     (stat_flits),
    .stat_stall     (stat_stall)
`endif
  );

  // Clock
  always #5 clk_noc = ~clk_noc;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  bit         auto_credit = 1'b0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] fl(input int c, input int p, input int i);
    return 32'hA000_0000 | FW'(c << 8) | FW'(p << 4) | FW'(i);
  endfunction

  task automatic drive(input int c, input logic [FW-1:0] d, input logic [DW-1:0] dst,
                       input logic tail);
    bus.ch_valid[c]   = 1'b1;
    bus.ch_data[c]    = d;
    bus.ch_dest[c]    = dst;
    bus.ch_is_tail[c] = tail;
  endtask

  task automatic expect_flit(input logic [FW-1:0] d, input logic [DW-1:0] dst, input logic tail);
    exp_q.push_back({dst, tail, d});
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge and sent flits
  // are checked against the expected queue.
  task automatic step();
    for (int c = 0; c < N; c++)
      if (bus.ch_valid[c]) chk($sformatf("ready_at_push_ch%0d", c), 64'(bus.ch_ready[c]), 64'd1);
    @(posedge clk_noc);
    #1;
    cyc++;
    bus.ch_valid  = '0;
    bus.credit_in = 1'b0;
    if (bus.send_out) begin
      chk($sformatf("sb_has_entry_c%0d", cyc), 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0)
        chk($sformatf("flit_c%0d", cyc), 64'({bus.dest_out, bus.is_tail_out, bus.data_out}),
            64'(exp_q.pop_front()));
      bus.credit_in = auto_credit;
    end
  endtask

  task automatic do_reset();
    rst_noc_sync  = 1'b1;
    bus.ch_valid  = '0;
    bus.credit_in = 1'b0;
    #1;
    chk("rst_ready_low", 64'(bus.ch_ready), 64'd0);
    @(posedge clk_noc);
    #1;
    exp_q.delete();
    chk("rst_send_out", 64'(bus.send_out), 64'd0);
    chk("rst_data_out", 64'(bus.data_out), 64'd0);
    chk("rst_dest_out", 64'(bus.dest_out), 64'd0);
    chk("rst_is_tail", 64'(bus.is_tail_out), 64'd0);
    chk("rst_credit_err", 64'(credit_err), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    chk("rst_rr_ptr", 64'(dbg_rr_ptr), 64'd0);
    chk("rst_credits", 64'(dbg_credit_cnt), 64'(CRED));
    chk("rst_ready_held", 64'(bus.ch_ready), 64'd0);
    rst_noc_sync = 1'b0;
    #1;
    chk("post_rst_ready", 64'(bus.ch_ready), 64'hF);
    cyc = 0;
  endtask

  initial begin
    rst_noc_sync   = 1'b1;
    bus.ch_valid   = '0;
    bus.ch_data    = '0;
    bus.ch_dest    = '0;
    bus.ch_is_tail = '0;
    bus.credit_in  = 1'b0;
    @(posedge clk_noc);
    #1;

    // Reset mid-packet: channel 1 locked after 2 non-tail flits, then reset.
    do_reset();
    auto_credit = 1'b1;
    drive(1, fl(1, 0, 0), 6'h11, 1'b0); expect_flit(fl(1, 0, 0), 6'h11, 1'b0);
    step();
    drive(1, fl(1, 0, 1), 6'h11, 1'b0); expect_flit(fl(1, 0, 1), 6'h11, 1'b0);
    step();
    step();
    chk("t1_locked_state", 64'(dbg_state), 64'(LOCKED));
    chk("t1_locked_ch", 64'(dbg_lock_ch), 64'd1);
    chk("t1_sb_drained", 64'(exp_q.size()), 64'd0);
    do_reset();
    drive(1, fl(1, 1, 0), 6'h21, 1'b1);
    drive(0, fl(0, 1, 0), 6'h20, 1'b1);
    expect_flit(fl(0, 1, 0), 6'h20, 1'b1);
    expect_flit(fl(1, 1, 0), 6'h21, 1'b1);
    step();
    chk("t1_latency_c1", 64'(bus.send_out), 64'd0);
    step();
    chk("t1_send_c2", 64'(bus.send_out), 64'd1);
    step();
    chk("t1_send_c3", 64'(bus.send_out), 64'd1);
    step();
    chk("t1_idle_c4", 64'(bus.send_out), 64'd0);
    chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("t1_credits_back", 64'(dbg_credit_cnt), 64'(CRED));

    // Single channel, no credit return: 2 flits then stall until credit at cycle 6.
    do_reset();
    auto_credit = 1'b0;
    drive(0, fl(0, 2, 0), 6'h05, 1'b0); expect_flit(fl(0, 2, 0), 6'h05, 1'b0);
    step();
    chk("t2_send_c1", 64'(bus.send_out), 64'd0);
    drive(0, fl(0, 2, 1), 6'h05, 1'b0); expect_flit(fl(0, 2, 1), 6'h05, 1'b0);
    step();
    chk("t2_send_c2", 64'(bus.send_out), 64'd1);
    drive(0, fl(0, 2, 2), 6'h05, 1'b1); expect_flit(fl(0, 2, 2), 6'h05, 1'b1);
    step();
    chk("t2_send_c3", 64'(bus.send_out), 64'd1);
    chk("t2_credits_c3", 64'(dbg_credit_cnt), 64'd0);
    step();
    chk("t2_stall_c4", 64'(bus.send_out), 64'd0);
    step();
    chk("t2_stall_c5", 64'(bus.send_out), 64'd0);
    chk("t2_locked_c5", 64'(dbg_state), 64'(LOCKED));
    step();
    chk("t2_stall_c6", 64'(bus.send_out), 64'd0);
    bus.credit_in = 1'b1;
    step();
    chk("t2_stall_c7", 64'(bus.send_out), 64'd0);
    chk("t2_credits_c7", 64'(dbg_credit_cnt), 64'd1);
    step();
    chk("t2_send_c8", 64'(bus.send_out), 64'd1);
    chk("t2_tail_c8", 64'(bus.is_tail_out), 64'd1);
    step();
    chk("t2_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("t2_state_idle", 64'(dbg_state), 64'(IDLE));

    // Four 2-flit packets, credits returned immediately: strict ch order, no interleave.
    do_reset();
    auto_credit = 1'b1;
    for (int c = 0; c < N; c++) drive(c, fl(c, 3, 0), DW'(6'h30 + c), 1'b0);
    step();
    for (int c = 0; c < N; c++) drive(c, fl(c, 3, 1), DW'(6'h30 + c), 1'b1);
    for (int c = 0; c < N; c++) begin
      expect_flit(fl(c, 3, 0), DW'(6'h30 + c), 1'b0);
      expect_flit(fl(c, 3, 1), DW'(6'h30 + c), 1'b1);
    end
    step();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t3_rate_%0d", k), 64'(bus.send_out), 64'd1);
      step();
    end
    chk("t3_done_send", 64'(bus.send_out), 64'd0);
    chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("t3_rr_wrap", 64'(dbg_rr_ptr), 64'd0);

    // Channel 2 locked with a late tail while channel 3 fills up.
    do_reset();
    auto_credit = 1'b1;
    drive(2, fl(2, 4, 0), 6'h24, 1'b0);
    drive(3, fl(3, 4, 0), 6'h34, 1'b0);
    expect_flit(fl(2, 4, 0), 6'h24, 1'b0);
    expect_flit(fl(2, 4, 1), 6'h24, 1'b1);
    for (int i = 0; i < 4; i++) expect_flit(fl(3, 4, i), 6'h34, (i == 3));
    step();
    drive(3, fl(3, 4, 1), 6'h34, 1'b0);
    step();
    chk("t4_send_c2", 64'(bus.send_out), 64'd1);
    drive(3, fl(3, 4, 2), 6'h34, 1'b0);
    step();
    chk("t4_bubble_c3", 64'(bus.send_out), 64'd0);
    drive(3, fl(3, 4, 3), 6'h34, 1'b1);
    step();
    chk("t4_bubble_c4", 64'(bus.send_out), 64'd0);
    chk("t4_ch3_full", 64'(bus.ch_ready[3]), 64'd0);
    chk("t4_lock_ch", 64'(dbg_lock_ch), 64'd2);
    drive(2, fl(2, 4, 1), 6'h24, 1'b1);
    step();
    chk("t4_bubble_c5", 64'(bus.send_out), 64'd0);
    step();
    chk("t4_tail_c6", 64'(bus.send_out), 64'd1);
    chk("t4_ch3_still_full", 64'(bus.ch_ready[3]), 64'd0);
    step();
    chk("t4_ch3_ready_back", 64'(bus.ch_ready[3]), 64'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t4_ch3_send_%0d", k), 64'(bus.send_out), 64'd1);
      step();
    end
    chk("t4_done_send", 64'(bus.send_out), 64'd0);
    chk("t4_sb_empty", 64'(exp_q.size()), 64'd0);

    // Credit return with the counter already full is a sticky error.
    do_reset();
    auto_credit = 1'b0;
    chk("t5_err_before", 64'(credit_err), 64'd0);
    bus.credit_in = 1'b1;
    step();
    chk("t5_err_set", 64'(credit_err), 64'd1);
    chk("t5_credits_sat", 64'(dbg_credit_cnt), 64'(CRED));
    step();
    step();
    chk("t5_err_sticky", 64'(credit_err), 64'd1);
    chk("t5_credits_hold", 64'(dbg_credit_cnt), 64'(CRED));
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
